// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width, receive FIFO depth and byte type.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: synchronous write, asynchronous read,
// small enough to map onto distributed RAM.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer between the UART receiver and the CPU registers.
// Define UART_RX_FIFO_OVF_EN to implement the sticky overflow flag; otherwise it reads 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_uart_rdata,
  input  logic              wr_uart_read_fin,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_uart_rdata,
  output logic              rd_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic              fin_q;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [DATA_W-1:0] mem_rdata;

  assign push     = wr_uart_read_fin & ~fin_q;
  assign rd_valid = (count != '0);
  assign full     = (count == FULL_COUNT);
  assign pop      = rd_en & rd_valid;
  // When full, a simultaneous pop frees the slot the new byte lands in.
  assign push_ok  = push & (~full | pop);

  // fin_q resets high so a strobe already asserted at reset release is not a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_q <= 1'b1;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      fin_q <= wr_uart_read_fin;
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop)     rptr <= rptr + ADDR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr),
    .wdata (wr_uart_rdata),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  // Mask the unreset array while empty so the CPU never sees X.
  assign rd_uart_rdata = rd_valid ? mem_rdata : '0;

`ifdef UART_RX_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push & ~push_ok) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed and randomized traffic against a queue model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH  = UART_RX_FIFO_DEPTH;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef UART_RX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  uart_byte_t      wr_uart_rdata;
  logic            wr_uart_read_fin;
  logic            rd_en;
  uart_byte_t      rd_uart_rdata;
  logic            rd_valid;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            ovf_clr;

  uart_rx_fifo dut (
    .clk              (clk),
    .rst              (rst),
    .wr_uart_rdata    (wr_uart_rdata),
    .wr_uart_read_fin (wr_uart_read_fin),
    .rd_en            (rd_en),
    .rd_uart_rdata    (rd_uart_rdata),
    .rd_valid         (rd_valid),
    .full             (full),
    .count            (count),
    .overflow         (overflow),
    .ovf_clr          (ovf_clr)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  uart_byte_t exp_q[$];
  int         msize;
  bit         m_ovf;
  bit         prev_fin;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        chk("pop_data", int'(rd_uart_rdata), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; the model decides the outcome at issue time.
  task automatic cycle(input bit fin, input uart_byte_t d, input bit rd, input bit clr);
    bit push, pop, push_ok;
    wr_uart_read_fin = fin;
    wr_uart_rdata    = d;
    rd_en            = rd;
    ovf_clr          = clr;
    push    = fin && !prev_fin;
    pop     = rd && (msize > 0);
    push_ok = push && ((msize < DEPTH) || pop);
    if (push_ok) exp_q.push_back(d);
    msize = msize + int'(push_ok) - int'(pop);
    if (OVF_EN) begin
      if (push && !push_ok) m_ovf = 1'b1;
      else if (clr)         m_ovf = 1'b0;
    end
    prev_fin = fin;
    @(posedge clk);
    #1;
    chk("count", int'(count), msize);
    chk("rd_valid", int'(rd_valid), int'(msize != 0));
    chk("full", int'(full), int'(msize == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (msize > 0) chk("head", int'(rd_uart_rdata), int'(exp_q[0]));
  endtask

  task automatic do_reset(input bit fin);
    rst              = 1'b1;
    wr_uart_read_fin = fin;
    wr_uart_rdata    = '0;
    rd_en            = 1'b0;
    ovf_clr          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    msize    = 0;
    m_ovf    = 1'b0;
    prev_fin = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
  endtask

  task automatic push_pulse(input uart_byte_t d);
    cycle(1'b1, d, 1'b0, 1'b0);
    cycle(1'b0, d, 1'b0, 1'b0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int next;
    @(posedge clk);
    #1;

    // Strobe held high across reset release must not push.
    do_reset(1'b1);
    repeat (3) cycle(1'b1, 8'h99, 1'b0, 1'b0);
    chk("fin_held_reset", int'(count), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    push_pulse(8'h41);
    push_pulse(8'h42);
    push_pulse(8'h43);
    chk("three_count", int'(count), 3);
    chk("three_head", int'(rd_uart_rdata), 8'h41);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_valid", int'(rd_valid), 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    repeat (5) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    chk("level_once", int'(count), 1);
    cycle(1'b0, 8'h55, 1'b1, 1'b0);

    // Overfill by one.
    for (int i = 0; i <= DEPTH; i++) push_pulse(uart_byte_t'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), DEPTH);
    chk("fill_ovf", int'(overflow), int'(OVF_EN));
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", int'(overflow), 0);
    repeat (DEPTH) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fill_drained", int'(count), 0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < DEPTH; i++) push_pulse(uart_byte_t'(8'h80 + i));
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullpp_count", int'(count), DEPTH);
    chk("fullpp_head", int'(rd_uart_rdata), 8'h81);
    repeat (DEPTH - 1) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpp_aa_head", int'(rd_uart_rdata), 8'hAA);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty FIFO: push with rd_en in the same cycle stores the byte.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_push_rd", int'(count), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized interleaving with wrap-around.
    next = 0;
    for (int c = 0; c < 2000 && (next < 40 || msize > 0); c++) begin
      bit fin, rd;
      fin = 1'b0;
      if (!prev_fin && next < 40 && msize < DEPTH && $urandom_range(0, 2) != 0) fin = 1'b1;
      rd = ($urandom_range(0, 2) == 0);
      cycle(fin, uart_byte_t'(next), rd, 1'b0);
      if (fin) next++;
      tests++;
      if (count > (ADDR_W+1)'(DEPTH)) begin
        fails++;
        $display("FAIL count_bound: got %0d, expected <= %0d", count, DEPTH);
      end
    end
    chk("random_all_pushed", next, 40);
    chk("random_drained", int'(count), 0);

    // Reset mid-operation discards contents.
    push_pulse(8'h11);
    push_pulse(8'h22);
    do_reset(1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx_fifo
